// File: rtl/dma_rb_pkg.sv
// dma_rb_pkg: shared types and default sizes for the DMA read-buffer drain scheduler.
//   state_t   : drain FSM states (idle / fill / close)
//   *_DEF     : default DW, PW, BUF_WORDS, AW
//   SRC_BIT   : bit of the read-buffer word that carries the source port id
package dma_rb_pkg;

    localparam int unsigned DW_DEF        = 512;
    localparam int unsigned PW_DEF        = 401;
    localparam int unsigned BUF_WORDS_DEF = 4096;
    localparam int unsigned AW_DEF        = 13;
    localparam int unsigned SRC_BIT       = DW_DEF - 1;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StClose
    } state_t;

endpackage

// File: rtl/dma_rb_drain_sched_rr_arb2.sv
// rr_arb2: two-requester arbiter with one-hot grant.
// Build option: define DMA_RB_RR_ARB_EN for round-robin; otherwise fixed priority (port 0 wins).
// Ports:
//   clk, reset (async, high), soft_rst (sync, high)
//   req[1:0]  : requests
//   advance   : a grant was taken this cycle; moves the round-robin pointer
//   gnt[1:0]  : one-hot grant (zero when no request)
module rr_arb2
    import dma_rb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       soft_rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

`ifdef DMA_RB_RR_ARB_EN
    // prio1 set: port 1 wins the next contended cycle (port 0 was granted last).
    logic prio1;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = prio1 ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio1 <= 1'b0;
        end else if (soft_rst) begin
            prio1 <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            prio1 <= gnt[0];
        end
    end
`else
    always_comb begin
        gnt = req[0] ? 2'b01 : {req[1], 1'b0};
    end

    // Pointer-related inputs have no use in the fixed-priority build.
    logic unused_rr;
    assign unused_rr = ^{clk, reset, soft_rst, advance};
`endif

endmodule

// File: rtl/dma_rb_drain_sched.sv
// dma_rb_drain_sched: drains two show-ahead NPU output ports into the ping-pong DMA read buffer.
// Build option: DMA_RB_RR_ARB_EN selects round-robin arbitration (default fixed priority).
// Ports:
//   clk, reset (async, high), soft_rst (sync, high, same effect as reset)
//   rb_ready[1:0] : half h free for writing (sampled only while idle)
//   rb_last[1:0]  : one-cycle pulse with the final write of half h
//   rb_wen, rb_waddr, rb_wdata, rb_wben : registered read-buffer write port
//   p0_/p1_rdy, p0_/p1_data : port head word; p0_/p1_ren pops it (combinational)
//   cur_half      : half owned or awaited
//   closed_cnt    : halves closed, wraps at 2^16
module dma_rb_drain_sched
    import dma_rb_pkg::*;
#(
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned PW        = PW_DEF,
    parameter int unsigned BUF_WORDS = BUF_WORDS_DEF,
    parameter int unsigned AW        = AW_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            soft_rst,
    input  logic [1:0]      rb_ready,
    output logic [1:0]      rb_last,
    output logic            rb_wen,
    output logic [AW-1:0]   rb_waddr,
    output logic [DW-1:0]   rb_wdata,
    output logic [DW/8-1:0] rb_wben,
    input  logic            p0_rdy,
    input  logic [PW-1:0]   p0_data,
    output logic            p0_ren,
    input  logic            p1_rdy,
    input  logic [PW-1:0]   p1_data,
    output logic            p1_ren,
    output logic            cur_half,
    output logic [15:0]     closed_cnt
);

    // idx is AW bits wide so it can represent BUF_WORDS itself.
    localparam logic [AW-1:0] FULL_IDX = AW'(BUF_WORDS);
    localparam logic [AW-1:0] LAST_IDX = AW'(BUF_WORDS - 1);

    state_t        state;
    logic [AW-1:0] idx;
    logic          can_grant;
    logic [1:0]    req;
    logic [1:0]    gnt;
    logic          grant;
    logic [DW-1:0] wword;

    // No pops outside FILL, past a full half, or while a soft reset is clearing state.
    assign can_grant = (state == StFill) && (idx < FULL_IDX) && !soft_rst;
    assign req       = {p1_rdy, p0_rdy} & {2{can_grant}};
    assign p0_ren    = gnt[0];
    assign p1_ren    = gnt[1];
    assign grant     = |gnt;

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .soft_rst (soft_rst),
        .req      (req),
        .advance  (grant),
        .gnt      (gnt)
    );

    // Port data in the low bits, port id in the top bit.
    always_comb begin
        wword          = '0;
        wword[PW-1:0]  = gnt[1] ? p1_data : p0_data;
        wword[DW-1]    = gnt[1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            idx        <= '0;
            cur_half   <= 1'b0;
            closed_cnt <= 16'd0;
            rb_last    <= 2'b00;
            rb_wen     <= 1'b0;
            rb_waddr   <= '0;
            rb_wdata   <= '0;
            rb_wben    <= '0;
        end else if (soft_rst) begin
            state      <= StIdle;
            idx        <= '0;
            cur_half   <= 1'b0;
            closed_cnt <= 16'd0;
            rb_last    <= 2'b00;
            rb_wen     <= 1'b0;
            rb_waddr   <= '0;
            rb_wdata   <= '0;
            rb_wben    <= '0;
        end else begin
            rb_wen  <= grant;
            rb_wben <= {(DW/8){grant}};
            rb_last <= 2'b00;
            if (grant) begin
                rb_waddr <= {cur_half, idx[AW-2:0]};
                rb_wdata <= wword;
                idx      <= idx + 1'b1;
            end
            unique case (state)
                StIdle: begin
                    if (rb_ready[cur_half]) begin
                        state <= StFill;
                        idx   <= '0;
                    end
                end
                StFill: begin
                    // last pulses alongside the final write of the half.
                    if (grant && (idx == LAST_IDX)) begin
                        state   <= StClose;
                        rb_last <= cur_half ? 2'b10 : 2'b01;
                    end
                end
                StClose: begin
                    cur_half   <= ~cur_half;
                    closed_cnt <= closed_cnt + 16'd1;
                    state      <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/dma_rb_drain_sched.md
# dma_rb_drain_sched

Drain scheduler between the NPU's two output ports and the double-buffered (ping-pong) DMA read buffer that the host polls. Arbitrates the two show-ahead NPU output ports word by word and writes their data into the half-buffer the block currently owns. It generates write addresses, closes each half with a one-cycle `last` pulse, then alternates halves. It replaces ad-hoc output draining in the shim with a single owner of the read-buffer write port.

## Interface
Parameters:
- `DW`, 512: read-buffer word width.
- `PW`, 401: NPU output port width; must be at most DW-1.
- `BUF_WORDS`, 4096: words per half-buffer; must be a power of two.
- `AW`, 13: read-buffer address width; equals log2(2*BUF_WORDS).

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `soft_rst` in 1: synchronous clear, active-high. Same effect as `reset`.
- `rb_ready` in 2: half *h* is free for NPU write. Level signal from the buffer-ownership logic.
- `rb_last` out 2: one-cycle pulse; half *h* is full and handed to the host.
- `rb_wen` out 1: read-buffer write enable.
- `rb_waddr` out AW: write address.
- `rb_wdata` out DW: write data.
- `rb_wben` out DW/8: byte enables; all ones whenever `rb_wen` is high.
- `p0_rdy` / `p1_rdy` in 1: port has a word available.
- `p0_data` / `p1_data` in PW: head word. Valid while the matching `rdy` is high.
- `p0_ren` / `p1_ren` out 1: pop the head word.
- `cur_half` out 1: half currently owned or awaited.
- `closed_cnt` out 16: count of halves closed; wraps at 2^16.

## Operation
- States: IDLE, FILL, CLOSE.
- **IDLE**
  - Waits for `rb_ready[cur_half]`.
  - On seeing it: go to FILL and set `idx`=0.
- **FILL**
  - Each cycle, if either `rdy` is high and `idx` < BUF_WORDS, grant exactly one port.
  - Assert that port's `ren` (combinational on `rdy`) and capture `{src_id, zero-extended data}` into the write register. Data sits in bits PW-1:0; bit DW-1 holds the port id (0 or 1).
  - Increment `idx` on each grant.
  - When the grant with `idx`==BUF_WORDS-1 is issued, go to CLOSE.
- **CLOSE**
  - Pulse `rb_last[cur_half]` for one cycle.
  - Toggle `cur_half`, increment `closed_cnt`, return to IDLE.
- Address: `rb_waddr` = `cur_half`*BUF_WORDS + write index. Half 0 covers 0..BUF_WORDS-1; half 1 covers BUF_WORDS..2*BUF_WORDS-1.
- `rb_ready` is sampled only in IDLE. Deassertion during FILL or CLOSE is ignored, because the block owns the half.
- No `ren` is issued outside FILL, and no `ren` is issued once `idx` reaches BUF_WORDS.
- Both `rdy` high in the same cycle: arbitration per Configuration.
- `reset` or `soft_rst` during FILL abandons the partial half. No `rb_last` pulse, no further writes.

## Timing
- Reset values:
  - state IDLE, `cur_half`=0, `idx`=0.
  - `rb_wen`=0, `rb_last`=0, `p0_ren`=`p1_ren`=0.
  - `rb_waddr`=0, `rb_wdata`=0, `rb_wben`=0.
  - `closed_cnt`=0, round-robin pointer = port 0.
- Grant at cycle T gives `rb_wen`/`rb_waddr`/`rb_wdata` registered at T+1.
- Final-word grant at T gives: final write at T+1, CLOSE at T+1, `rb_last` high during T+1, IDLE at T+2.
- `rb_last` therefore coincides with the last `rb_wen`. The consumer flags the half valid on the following edge, after the write commits.
- IDLE to FILL takes 1 cycle after `rb_ready[cur_half]` is seen. The first grant can occur in the first FILL cycle.
- Sustained throughput is 1 word/cycle. A half takes BUF_WORDS+2 cycles minimum, including IDLE and CLOSE.

## Configuration
- Macro `DMA_RB_RR_ARB_EN`.
- Defined: 2-way round-robin. On a contended grant, the port not granted last wins. The pointer updates on every grant.
- Undefined: fixed priority, port 0 wins. `p1` is granted only when `p0_rdy` is low.

## Structure
- Package `dma_rb_pkg` holds:
  - state enum (IDLE, FILL, CLOSE),
  - defaults for DW/PW/BUF_WORDS/AW,
  - `SRC_BIT` = DW-1.
- Sub-module `rr_arb2`:
  - inputs: 2-bit request, advance;
  - output: one-hot grant;
  - contains the pointer;
  - fixed-priority variant selected by the macro.

## Test plan
- **Single port:** `rb_ready`=2'b11, only `p0_rdy`, BUF_WORDS=8.
  - 8 writes to addresses 0..7 with bit 511=0.
  - `rb_last`=2'b01 with the 8th write.
  - Then addresses 8..15, `rb_last`=2'b10.
  - `closed_cnt`=2.
- **Contention, RR enabled:** both ports always ready.
  - Grants alternate 0,1,0,1…; bit 511 toggles per write.
  - With the macro undefined: all eight words come from port 0.
- **Ownership stall:** `rb_ready[1]`=0 after half 0 closes.
  - Block stays in IDLE, no `ren`, `cur_half`=1.
  - Raise `rb_ready[1]`: the first write is at address BUF_WORDS, 2 cycles later.
- **Bubbles:** `p0_rdy` toggles every other cycle, `p1` idle.
  - Writes are contiguous in address with no gaps or duplicates.
  - `last` is asserted only on word BUF_WORDS-1.
- **Mid-fill reset:** `soft_rst` pulse after 3 of 8 words.
  - No `rb_last`; `cur_half`=0; `idx`=0.
  - The next fill restarts at address 0.
  - Repeat with async `reset` asserted mid-cycle: outputs clear immediately.
